sync_ram: RTL and testbench
===========================

# sync_ram

Parametrised single-port synchronous RAM, successor to the 32 x 32 scratch memory used by the datapath. It has configurable width and depth, byte-lane write enables, a registered read port with a `data_valid` strobe, and a hardware clear engine. The clear engine zeroes every word after reset, or on request, while asserting `busy`. It drops into the same datapath slot as the previous memory; users gate accesses on `busy`.

## Interface
- `DATA_WIDTH`, default 32: word width in bits. Must be a multiple of 8.
- `ADDR_WIDTH`, default 5: address width in bits. Depth `DEPTH = 2**ADDR_WIDTH`, default 32 words.
- `clock`, input, 1: sole clock. All state updates on its rising edge.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `chip_select`, input, 1: access request, sampled each rising edge.
- `we`, input, 1: 1 = write, 0 = read. Meaningful only with `chip_select`.
- `byte_en`, input, DATA_WIDTH/8: per-lane write enable. Lane i covers bits [8i+7:8i].
- `address`, input, ADDR_WIDTH: word address.
- `data_in`, input, DATA_WIDTH: write data.
- `clear`, input, 1: single-cycle request to zero the whole array.
- `data_out`, output, DATA_WIDTH: registered read data. Holds its value between reads.
- `data_valid`, output, 1: high for exactly one cycle when `data_out` carries fresh read data.
- `busy`, output, 1: clear sweep in progress. Accesses are ignored while high.

## Operation
- FSM states: CLEAR and IDLE.
  - CLEAR: one word written per cycle, all bits 0, at internal counter `clr_addr`. `clr_addr` counts 0 to DEPTH-1.
  - After writing DEPTH-1, the FSM moves to IDLE and `clr_addr` returns to 0.
- Reset (`reset_n` low at a rising edge):
  - Outputs: `data_out`=0, `data_valid`=0, `busy`=1.
  - Internal: state=CLEAR, `clr_addr`=0.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- Accepted access: `chip_select`=1, state=IDLE, and `clear`=0.
  - Write (`we`=1): for each lane with `byte_en[i]`=1, `mem[address]` lane i <= `data_in` lane i. Other lanes keep their value.
  - Write with `byte_en` all zero is legal and changes nothing.
  - Write does not change `data_out` and does not raise `data_valid`.
  - Read (`we`=0): `data_out` <= `mem[address]`, and `data_valid` <= 1.
- Cycles with no accepted read: `data_valid` <= 0 and `data_out` holds.
- `clear` sampled high in IDLE: the FSM enters CLEAR at that edge and `busy` rises.
  - Any access presented in the same cycle is dropped; `clear` has priority.
- `clear` sampled high while in CLEAR is ignored. The sweep does not restart.
- Accesses presented while `busy`=1 are dropped silently. No error flag.
- No out-of-range addresses exist, because DEPTH equals 2**ADDR_WIDTH.

## Timing
- Read latency is 1 cycle. A read accepted at edge N presents data and `data_valid`=1 after edge N. `data_valid` falls after N+1 unless another read is accepted at N+1.
- Back-to-back reads give one word per cycle, with `data_valid` held continuously high.
- Read and write to the same address cannot be presented in one cycle (single port).
- A read accepted at edge N+1, following a write at N to the same address, returns the written data.
- Clear sweep timing:
  - Edges E1..E_DEPTH, the first edges with `reset_n`=1 or after `clear` is accepted, write addresses 0..DEPTH-1.
  - `busy` is low after E_DEPTH. The first accepted access is at E_DEPTH+1.
  - With the `clear` path, the accepting edge itself is E0: it enters CLEAR and writes nothing. E1 then writes address 0.
- `busy` is a registered state decode with no combinational path from inputs.

## Test plan
- Reset, then hold `reset_n` high with default params: `busy`=1 for exactly 32 cycles and then 0. Reading addresses 0..31 returns 0x00000000, with `data_valid` pulsing one cycle per read.
- Byte lanes: write 0xDEADBEEF with `byte_en`=4'b1111 to address 5, then write 0x11223344 with 4'b0101 to address 5. A read of address 5 returns 0xDE22BE44 one cycle later.
- Back-to-back: write address k with value k*0x01010101 for k=0..31, then read 31 down to 0 on consecutive cycles. Expect a continuous `data_valid` and correct data in order.
- Clear priority: with `clear`=1, `chip_select`=1, `we`=1, address 3, data 0xFFFFFFFF in the same cycle, the write is dropped. After `busy` falls, address 3 reads 0.
- Reset mid-sweep: assert `reset_n`=0 during sweep cycle 10 of a `clear`. `busy` stays 1 for a full 32 cycles after release, and all words read 0.
- Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=3. The sweep lasts 8 cycles, `byte_en` is 2 bits, and a write of 0xA5A5 with 2'b10 to 0 reads back 0xA500.

Source files
------------

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with byte-lane writes, registered read port and
// a clear engine that zeroes the array after reset or on request.
module sync_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    chip_select,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    clear,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
  output logic                    busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned LANES = DATA_WIDTH / 8;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic accept;
  logic wr_en;
  logic rd_en;

  // clear has priority over any access presented in the same cycle
  assign accept = chip_select && (state == S_IDLE) && !clear;
  assign wr_en  = accept && we;
  assign rd_en  = accept && !we;
  assign busy   = (state == S_CLEAR);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= S_CLEAR;
      clr_addr   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_en;
      if (rd_en) begin
        data_out <= mem[address];
      end
      case (state)
        S_CLEAR: begin
          if (clr_addr == '1) begin
            state    <= S_IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_WIDTH'(1);
          end
        end
        S_IDLE: begin
          if (clear) begin
            state    <= S_CLEAR;
            clr_addr <= '0;
          end
        end
        default: begin
          state    <= S_CLEAR;
          clr_addr <= '0;
        end
      endcase
    end
  end

  // Array carries no reset; the sweep zeroes it starting the first edge after reset
  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (state == S_CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr_en) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          if (byte_en[i]) begin
            mem[address][i*8 +: 8] <= data_in[i*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sync_ram.sv
// Scoreboarded bench for sync_ram: default 32x32 instance plus a 16x8 instance.
module tb_sync_ram;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_n, cs, we, clr;
  logic [3:0]  be;
  logic [4:0]  addr;
  logic [31:0] din, dout;
  logic        dv, busy;

  logic        s_rst_n, s_cs, s_we, s_clr;
  logic [1:0]  s_be;
  logic [2:0]  s_addr;
  logic [15:0] s_din, s_dout;
  logic        s_dv, s_busy;

  sync_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock(clock), .reset_n(rst_n), .chip_select(cs), .we(we), .byte_en(be),
    .address(addr), .data_in(din), .clear(clr), .data_out(dout),
    .data_valid(dv), .busy(busy)
  );

  sync_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut_s (
    .clock(clock), .reset_n(s_rst_n), .chip_select(s_cs), .we(s_we), .byte_en(s_be),
    .address(s_addr), .data_in(s_din), .clear(s_clr), .data_out(s_dout),
    .data_valid(s_dv), .busy(s_busy)
  );

  int total = 0;
  int bad   = 0;
  logic [31:0] ref_mem [32];
  logic [31:0] exp_q [$];
  logic [15:0] s_q [$];

  task automatic drive(input logic c, input logic w, input logic [3:0] b,
                       input logic [4:0] a, input logic [31:0] d, input logic cl);
    cs = c; we = w; be = b; addr = a; din = d; clr = cl;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b0);
  endtask

  task automatic model_write(input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
    for (int i = 0; i < 4; i++)
      if (b[i]) ref_mem[a][i*8 +: 8] = d[i*8 +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    idle();
    @(negedge clock);
    @(negedge clock);
    total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h want=00000000", dout); end
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL reset_dv got=%b want=0", dv); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
    rst_n = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clock);
      n++;
      if (busy !== 1'b1 || n > 200) break;
    end
    total++; if (n != 32) begin bad++; $display("FAIL reset_sweep_len got=%0d want=32", n); end
    model_clear();
  endtask

  task automatic test_read_all(input bit descending, input string tag);
    logic [31:0] exp, prev;
    int a;
    exp = 32'h0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      if (k > 0) begin
        exp = exp_q.pop_front();
        total++;
        if (dv !== 1'b1 || dout !== exp) begin
          bad++;
          $display("FAIL %s_read[%0d] got dout=%h dv=%b want dout=%h dv=1", tag, k-1, dout, dv, exp);
        end
      end
      a = descending ? 31 - k : k;
      drive(1'b1, 1'b0, 4'h0, 5'(a), 32'h0, 1'b0);
      exp_q.push_back(ref_mem[a]);
    end
    @(negedge clock);
    exp = exp_q.pop_front();
    total++;
    if (dv !== 1'b1 || dout !== exp) begin
      bad++;
      $display("FAIL %s_read[31] got dout=%h dv=%b want dout=%h dv=1", tag, dout, dv, exp);
    end
    prev = exp;
    idle();
    @(negedge clock);
    total++;
    if (dv !== 1'b0 || dout !== prev) begin
      bad++;
      $display("FAIL %s_hold got dout=%h dv=%b want dout=%h dv=0", tag, dout, dv, prev);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] hold, exp;
    hold = dout;
    @(negedge clock);
    drive(1'b1, 1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 1'b0);
    model_write(5'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clock);
    total++;
    if (dv !== 1'b0 || dout !== hold) begin
      bad++; $display("FAIL write_no_dv got dout=%h dv=%b want dout=%h dv=0", dout, dv, hold);
    end
    drive(1'b1, 1'b1, 4'b0101, 5'd5, 32'h11223344, 1'b0);
    model_write(5'd5, 4'b0101, 32'h11223344);
    @(negedge clock);
    drive(1'b1, 1'b1, 4'b0000, 5'd5, 32'hFFFFFFFF, 1'b0);
    @(negedge clock);
    total++;
    if (dv !== 1'b0) begin bad++; $display("FAIL zero_lane_write_dv got=%b want=0", dv); end
    drive(1'b1, 1'b0, 4'h0, 5'd5, 32'h0, 1'b0);
    exp_q.push_back(32'hDE22BE44);
    @(negedge clock);
    exp = exp_q.pop_front();
    total++;
    if (dv !== 1'b1 || dout !== exp) begin
      bad++; $display("FAIL byte_lanes got dout=%h dv=%b want dout=%h dv=1", dout, dv, exp);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 32; k++) begin
      @(negedge clock);
      drive(1'b1, 1'b1, 4'hF, 5'(k), 32'(k) * 32'h01010101, 1'b0);
      model_write(5'(k), 4'hF, 32'(k) * 32'h01010101);
    end
    test_read_all(1'b1, "b2b");
  endtask

  task automatic test_clear_priority();
    int n;
    @(negedge clock);
    drive(1'b1, 1'b1, 4'hF, 5'd3, 32'hFFFFFFFF, 1'b1);
    model_clear();
    @(negedge clock);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL clear_busy_rise got=%b want=1", busy); end
    total++; if (dv !== 1'b0) begin bad++; $display("FAIL clear_dv got=%b want=0", dv); end
    idle();
    n = 0;
    while (1) begin
      @(negedge clock);
      n++;
      if (busy !== 1'b1 || n > 200) break;
      if (n == 5) drive(1'b1, 1'b1, 4'hF, 5'd7, 32'hFFFFFFFF, 1'b1);
      else idle();
    end
    total++; if (n != 32) begin bad++; $display("FAIL clear_sweep_len got=%0d want=32", n); end
    idle();
    test_read_all(1'b0, "clr");
  endtask

  task automatic test_reset_mid_sweep();
    logic [31:0] exp;
    int n;
    @(negedge clock);
    drive(1'b1, 1'b1, 4'hF, 5'd9, 32'h12345678, 1'b0);
    model_write(5'd9, 4'hF, 32'h12345678);
    @(negedge clock);
    drive(1'b1, 1'b0, 4'h0, 5'd9, 32'h0, 1'b0);
    exp_q.push_back(ref_mem[9]);
    @(negedge clock);
    exp = exp_q.pop_front();
    total++;
    if (dv !== 1'b1 || dout !== exp) begin
      bad++; $display("FAIL pre_reset_read got dout=%h dv=%b want dout=%h dv=1", dout, dv, exp);
    end
    drive(1'b0, 1'b0, 4'h0, 5'd0, 32'h0, 1'b1);
    model_clear();
    for (int i = 0; i < 11; i++) begin
      @(negedge clock);
      idle();
    end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_sweep_busy got=%b want=1", busy); end
    rst_n = 1'b0;
    @(negedge clock);
    total++;
    if (dout !== 32'h0 || dv !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_reset_outputs got dout=%h dv=%b busy=%b want 00000000 0 1", dout, dv, busy);
    end
    rst_n = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clock);
      n++;
      if (busy !== 1'b1 || n > 200) break;
    end
    total++; if (n != 32) begin bad++; $display("FAIL mid_reset_sweep_len got=%0d want=32", n); end
    test_read_all(1'b0, "rst");
  endtask

  task automatic test_param();
    logic [15:0] exp;
    int n;
    s_rst_n = 1'b0;
    s_cs = 1'b0; s_we = 1'b0; s_be = 2'b00; s_addr = 3'd0; s_din = 16'h0; s_clr = 1'b0;
    @(negedge clock);
    total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL small_reset_busy got=%b want=1", s_busy); end
    s_rst_n = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clock);
      n++;
      if (s_busy !== 1'b1 || n > 200) break;
    end
    total++; if (n != 8) begin bad++; $display("FAIL small_sweep_len got=%0d want=8", n); end
    s_cs = 1'b1; s_we = 1'b1; s_be = 2'b10; s_addr = 3'd0; s_din = 16'hA5A5;
    @(negedge clock);
    s_we = 1'b0; s_be = 2'b00; s_addr = 3'd0; s_din = 16'h0;
    s_q.push_back(16'hA500);
    @(negedge clock);
    exp = s_q.pop_front();
    total++;
    if (s_dv !== 1'b1 || s_dout !== exp) begin
      bad++; $display("FAIL small_lane_read got dout=%h dv=%b want dout=%h dv=1", s_dout, s_dv, exp);
    end
    s_addr = 3'd7;
    s_q.push_back(16'h0000);
    @(negedge clock);
    exp = s_q.pop_front();
    total++;
    if (s_dv !== 1'b1 || s_dout !== exp) begin
      bad++; $display("FAIL small_top_read got dout=%h dv=%b want dout=%h dv=1", s_dout, s_dv, exp);
    end
    s_cs = 1'b0;
    @(negedge clock);
    total++; if (s_dv !== 1'b0) begin bad++; $display("FAIL small_dv_fall got=%b want=0", s_dv); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    s_rst_n = 1'b0;
    s_cs = 1'b0; s_we = 1'b0; s_be = 2'b00; s_addr = 3'd0; s_din = 16'h0; s_clr = 1'b0;
    test_reset();
    test_read_all(1'b0, "init");
    test_byte_lanes();
    test_back_to_back();
    test_clear_priority();
    test_reset_mid_sweep();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
